// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: op encodings, sizing and the entry record.
package rob_pkg;

  localparam int ROB_SIZE = 16;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_JALR   = 2'd3
  } rob_op_e;

  typedef struct packed {
    rob_op_e     op;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] value;
    logic [31:0] alt_pc;
    logic        pred_taken;
  } rob_entry_t;

  // An index is busy when its distance from head (mod ROB_SIZE) is below count.
  function automatic logic rob_busy(input logic [IDX_W-1:0] idx,
                                    input logic [IDX_W-1:0] head,
                                    input logic [IDX_W:0]   count);
    logic [IDX_W-1:0] off;
    off = idx - head;
    return {1'b0, off} < count;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB capture, operand lookup and commit signals of the reorder buffer.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic              rdy;
  logic              dec_valid;
  logic [1:0]        dec_op;
  logic [4:0]        dec_rd;
  logic              dec_pred_taken;
  logic [31:0]       dec_alt_pc;
  logic [IDX_W-1:0]  alloc_idx;
  logic              full;
  logic              alu_flag;
  logic [31:0]       alu_val;
  logic [IDX_W-1:0]  alu_idx;
  logic              lsb_flag;
  logic [31:0]       lsb_val;
  logic [IDX_W-1:0]  lsb_idx;
  logic [IDX_W-1:0]  q1_idx;
  logic [IDX_W-1:0]  q2_idx;
  logic              q1_ready;
  logic              q2_ready;
  logic [31:0]       q1_val;
  logic [31:0]       q2_val;
  logic              commit_rf_valid;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_val;
  logic [IDX_W-1:0]  commit_idx;
  logic              commit_store_valid;
  logic              jump_wrong;
  logic [31:0]       jump_pc;

  modport master (
    output rdy, dec_valid, dec_op, dec_rd, dec_pred_taken, dec_alt_pc,
           alu_flag, alu_val, alu_idx, lsb_flag, lsb_val, lsb_idx, q1_idx, q2_idx,
    input  alloc_idx, full, q1_ready, q2_ready, q1_val, q2_val,
           commit_rf_valid, commit_rd, commit_val, commit_idx, commit_store_valid,
           jump_wrong, jump_pc
  );

  modport slave (
    input  rdy, dec_valid, dec_op, dec_rd, dec_pred_taken, dec_alt_pc,
           alu_flag, alu_val, alu_idx, lsb_flag, lsb_val, lsb_idx, q1_idx, q2_idx,
    output alloc_idx, full, q1_ready, q2_ready, q1_val, q2_val,
           commit_rf_valid, commit_rd, commit_val, commit_idx, commit_store_valid,
           jump_wrong, jump_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags, captures CDB results, answers operand
// lookups and retires one entry per cycle through registered commit/flush pulses.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob_if
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_MAX = (IDX_W+1)'(ROB_SIZE);

  rob_entry_t       r_ent [ROB_SIZE];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic             r_commit_rf_valid;
  logic             r_commit_store_valid;
  logic             r_jump_wrong;
  logic [4:0]       r_commit_rd;
  logic [31:0]      r_commit_val;
  logic [IDX_W-1:0] r_commit_idx;
  logic [31:0]      r_jump_pc;

  rob_entry_t  w_head_ent;
  rob_entry_t  w_new_ent;
  logic        w_full;
  logic        w_commit;
  logic        w_alloc;
  logic        w_alu_hit;
  logic        w_lsb_hit;
  logic        w_rf;
  logic        w_st;
  logic        w_jw;
  logic [31:0] w_cval;
  logic [31:0] w_jpc;

  assign w_head_ent = r_ent[r_head];
  assign w_full     = (r_count == CNT_MAX);
  assign w_commit   = rob_if.rdy && (r_count != '0) && w_head_ent.ready;
  assign w_alloc    = rob_if.rdy && rob_if.dec_valid && !w_full && !w_jw;
  assign w_alu_hit  = rob_if.rdy && rob_if.alu_flag && rob_busy(rob_if.alu_idx, r_head, r_count);
  assign w_lsb_hit  = rob_if.rdy && rob_if.lsb_flag && rob_busy(rob_if.lsb_idx, r_head, r_count);

  assign w_new_ent = '{op: rob_op_e'(rob_if.dec_op), rd: rob_if.dec_rd, ready: 1'b0,
                       value: 32'd0, alt_pc: rob_if.dec_alt_pc,
                       pred_taken: rob_if.dec_pred_taken};

  always_comb begin
    w_rf   = 1'b0;
    w_st   = 1'b0;
    w_jw   = 1'b0;
    w_cval = w_head_ent.value;
    w_jpc  = w_head_ent.alt_pc;
    if (w_commit) begin
      case (w_head_ent.op)
        ROB_REG:    w_rf = (w_head_ent.rd != 5'd0);
        ROB_STORE:  w_st = 1'b1;
        ROB_BRANCH: w_jw = (w_head_ent.value[0] != w_head_ent.pred_taken);
        ROB_JALR: begin
          w_rf   = (w_head_ent.rd != 5'd0);
          w_cval = w_head_ent.alt_pc;
          w_jw   = 1'b1;
          w_jpc  = {w_head_ent.value[31:1], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // ALU is written after LSB so it wins when both hit the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) r_ent[i] <= '0;
    end else begin
      if (w_alloc) r_ent[r_tail] <= w_new_ent;
      if (w_lsb_hit) begin
        r_ent[rob_if.lsb_idx].ready <= 1'b1;
        r_ent[rob_if.lsb_idx].value <= rob_if.lsb_val;
      end
      if (w_alu_hit) begin
        r_ent[rob_if.alu_idx].ready <= 1'b1;
        r_ent[rob_if.alu_idx].value <= rob_if.alu_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_jw) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + IDX_ONE;
      if (w_commit) r_head <= r_head + IDX_ONE;
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_rf_valid    <= 1'b0;
      r_commit_store_valid <= 1'b0;
      r_jump_wrong         <= 1'b0;
      r_commit_rd          <= '0;
      r_commit_val         <= '0;
      r_commit_idx         <= '0;
      r_jump_pc            <= '0;
    end else begin
      r_commit_rf_valid    <= w_rf;
      r_commit_store_valid <= w_st;
      r_jump_wrong         <= w_jw;
      if (w_commit) begin
        r_commit_rd  <= w_head_ent.rd;
        r_commit_val <= w_cval;
        r_commit_idx <= r_head;
      end
      if (w_jw) r_jump_pc <= w_jpc;
    end
  end

  // Same-cycle CDB results bypass the entry array, ALU first.
  function automatic logic [32:0] f_lookup(
    input logic [IDX_W-1:0] q, input rob_entry_t ent,
    input logic af, input logic [IDX_W-1:0] ai, input logic [31:0] av,
    input logic lf, input logic [IDX_W-1:0] li, input logic [31:0] lv);
    if (af && ai == q) return {1'b1, av};
    if (lf && li == q) return {1'b1, lv};
    return {ent.ready, ent.value};
  endfunction

  assign {rob_if.q1_ready, rob_if.q1_val} = f_lookup(rob_if.q1_idx, r_ent[rob_if.q1_idx],
      rob_if.alu_flag, rob_if.alu_idx, rob_if.alu_val, rob_if.lsb_flag, rob_if.lsb_idx, rob_if.lsb_val);
  assign {rob_if.q2_ready, rob_if.q2_val} = f_lookup(rob_if.q2_idx, r_ent[rob_if.q2_idx],
      rob_if.alu_flag, rob_if.alu_idx, rob_if.alu_val, rob_if.lsb_flag, rob_if.lsb_idx, rob_if.lsb_val);

  assign rob_if.alloc_idx          = r_tail;
  assign rob_if.full               = w_full;
  assign rob_if.commit_rf_valid    = r_commit_rf_valid;
  assign rob_if.commit_store_valid = r_commit_store_valid;
  assign rob_if.jump_wrong         = r_jump_wrong;
  assign rob_if.commit_rd          = r_commit_rd;
  assign rob_if.commit_val         = r_commit_val;
  assign rob_if.commit_idx         = r_commit_idx;
  assign rob_if.jump_pc            = r_jump_pc;

endmodule
